// File: rtl/msk_tk3_sched_ctrl_if.sv
// Share-word load bus into the TK3 schedule sequencer; one word moves per cycle with in_valid & in_ready.
interface msk_tk3_sched_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/msk_tk3_sched_ctrl.sv
// Loads a d-share tweakey into a bit-interleaved masked buffer, then sequences ROUNDS key-schedule steps.
// INIT one cycle after the last word, rk_valid the cycle after; hold stalls RUN, in_ready only high in LOAD.
module msk_tk3_sched_ctrl #(
  parameter int d      = 2,
  parameter int ROUNDS = 56,
  parameter int RW     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  msk_tk3_sched_ctrl_if.slave  bus,
  input  logic                 hold,
  output logic [128*d-1:0]     K,
  output logic                 sel,
  output logic                 en,
  output logic                 rk_valid,
  output logic [RW-1:0]        rk_round,
  output logic                 done
);

  localparam int NW = 4 * d;
  localparam int CW = $clog2(NW);
  localparam int SW = CW - 2;

  typedef enum logic [1:0] {S_LOAD, S_INIT, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_wcnt;
  logic [128*d-1:0]   r_k;
  logic [RW-1:0]      r_rk_round;
  logic               r_in_ready;
  logic               r_init;
  logic               r_rk_valid;
  logic               r_done;

  logic               w_wr;
  logic               w_last;
  logic [1:0]         w_word;
  logic [SW-1:0]      w_share;
  logic [128*d-1:0]   w_k_nxt;

  assign w_wr    = bus.in_valid & r_in_ready;
  assign w_last  = (r_rk_round == RW'(ROUNDS - 1));
  assign w_word  = r_wcnt[1:0];
  assign w_share = r_wcnt[CW-1:2];

  // Each incoming word touches only its own share's bits; other shares never mix in.
  for (genvar s = 0; s < d; s++) begin : g_share
    for (genvar j = 0; j < 128; j++) begin : g_bit
      assign w_k_nxt[j*d+s] = (w_wr && w_share == SW'(s) && w_word == 2'(j / 32))
                              ? bus.in_data[j % 32] : r_k[j*d+s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_wcnt     <= '0;
      r_k        <= '0;
      r_rk_round <= '0;
      r_in_ready <= 1'b1;
      r_init     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_k <= w_k_nxt;
      case (r_state)
        S_LOAD: begin
          if (w_wr) begin
            if (r_wcnt == CW'(NW - 1)) begin
              r_wcnt     <= '0;
              r_state    <= S_INIT;
              r_in_ready <= 1'b0;
              r_init     <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + CW'(1);
            end
          end
        end
        S_INIT: begin
          r_state    <= S_RUN;
          r_init     <= 1'b0;
          r_rk_valid <= 1'b1;
          r_rk_round <= '0;
        end
        S_RUN: begin
          if (!hold) begin
            if (w_last) begin
              r_state    <= S_DONE;
              r_rk_valid <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_rk_round <= r_rk_round + RW'(1);
            end
          end
        end
        S_DONE: begin
          r_state    <= S_LOAD;
          r_done     <= 1'b0;
          r_k        <= '0;
          r_in_ready <= 1'b1;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // en/sel in RUN follow hold in the same cycle so a stall freezes the stage immediately.
  assign en           = r_init | (r_rk_valid & ~hold & ~w_last);
  assign sel          = r_rk_valid;
  assign bus.in_ready = r_in_ready & ~rst;
  assign K            = r_k;
  assign rk_valid     = r_rk_valid;
  assign rk_round     = r_rk_round;
  assign done         = r_done;

endmodule

// File: tb/tb_msk_tk3_sched_ctrl.sv
// Randomized bench for msk_tk3_sched_ctrl against a share-array packing model and a hold-count round model.
module tb_msk_tk3_sched_ctrl;
  localparam int D      = 2;
  localparam int ROUNDS = 56;
  localparam int RW     = 6;
  localparam int KW     = 128 * D;
  localparam int IW     = $clog2(KW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic [KW-1:0] K;
  logic          sel, en, rk_valid, done;
  logic [RW-1:0] rk_round;

  msk_tk3_sched_ctrl_if bus ();

  msk_tk3_sched_ctrl #(.d(D), .ROUNDS(ROUNDS), .RW(RW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .hold(hold), .K(K), .sel(sel),
    .en(en), .rk_valid(rk_valid), .rk_round(rk_round), .done(done)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [KW-1:0] exp_k;
  logic [31:0]   wq [4*D];

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Word n is share n/4, word n%4; its bit b is tweakey bit 32*(n%4)+b, stored at index bit*D+share.
  function automatic void put_word(input int n, input logic [31:0] w);
    for (int b = 0; b < 32; b++)
      exp_k[IW'((32 * (n % 4) + b) * D + n / 4)] = w[5'(b)];
  endfunction

  task automatic load_key(input int abort_after, input int max_gap);
    for (int n = 0; n < 4 * D; n++) begin
      int gap;
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_data = $urandom; hold = 1'($urandom_range(0, 1));
        #1;
        chk("gap_rdy", KW'(bus.in_ready), KW'(1));
        chk("gap_k", K, exp_k);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = wq[n]; hold = 1'($urandom_range(0, 1));
      #1;
      chk("load_rdy", KW'(bus.in_ready), KW'(1));
      chk("load_k", K, exp_k);
      chk("load_en", KW'(en), KW'(0));
      put_word(n, wq[n]);
      if (n + 1 == abort_after) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("ldrst_rdy", KW'(bus.in_ready), KW'(0));
        chk("ldrst_kpart", K, exp_k);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        exp_k = '0;
        chk("ldrst_k", K, exp_k);
        chk("ldrst_rdy1", KW'(bus.in_ready), KW'(1));
        chk("ldrst_round", KW'(rk_round), KW'(0));
        return;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'($urandom_range(0, 1)); bus.in_data = 32'hDEADBEEF; hold = 1'($urandom_range(0, 1));
    #1;
    chk("init_rdy", KW'(bus.in_ready), KW'(0));
    chk("init_sel", KW'(sel), KW'(0));
    chk("init_en", KW'(en), KW'(1));
    chk("init_vld", KW'(rk_valid), KW'(0));
    chk("init_k", K, exp_k);
  endtask

  // Expected round index = number of non-held RUN cycles so far; the ROUNDS-th one ends RUN.
  task automatic run_phase(input int stall_at, input int stall_len, input int rst_at, input bit rnd_hold);
    int   adv;
    int   left;
    logic h;
    adv  = 0;
    left = stall_len;
    while (adv < ROUNDS) begin
      @(posedge clk); #1;
      if (adv == stall_at && left > 0) begin
        h = 1'b1; left--;
      end else if (rnd_hold) begin
        h = ($urandom_range(0, 3) == 0);
      end else begin
        h = 1'b0;
      end
      hold = h; bus.in_valid = 1'($urandom_range(0, 1)); bus.in_data = 32'hDEADBEEF;
      if (adv == rst_at) rst = 1'b1;
      #1;
      chk("run_vld", KW'(rk_valid), KW'(1));
      chk("run_round", KW'(rk_round), KW'(adv));
      chk("run_en", KW'(en), KW'(!h && adv < ROUNDS - 1));
      if (h || adv < ROUNDS - 1) chk("run_sel", KW'(sel), KW'(1));
      chk("run_rdy", KW'(bus.in_ready), KW'(0));
      chk("run_done", KW'(done), KW'(0));
      chk("run_k", K, exp_k);
      if (rst) begin
        @(posedge clk); #1;
        rst = 1'b0; hold = 1'b0; bus.in_valid = 1'b0;
        #1;
        exp_k = '0;
        chk("rrst_vld", KW'(rk_valid), KW'(0));
        chk("rrst_en", KW'(en), KW'(0));
        chk("rrst_k", K, exp_k);
        chk("rrst_round", KW'(rk_round), KW'(0));
        chk("rrst_done", KW'(done), KW'(0));
        chk("rrst_rdy", KW'(bus.in_ready), KW'(1));
        return;
      end
      if (!h) adv++;
    end
    @(posedge clk); #1;
    hold = 1'($urandom_range(0, 1)); bus.in_valid = 1'b0;
    #1;
    chk("done_pulse", KW'(done), KW'(1));
    chk("done_vld", KW'(rk_valid), KW'(0));
    chk("done_en", KW'(en), KW'(0));
    @(posedge clk); #1;
    hold = 1'b0;
    #1;
    exp_k = '0;
    chk("post_k", K, exp_k);
    chk("post_done", KW'(done), KW'(0));
    chk("post_rdy", KW'(bus.in_ready), KW'(1));
    chk("post_round", KW'(rk_round), KW'(ROUNDS - 1));
  endtask

  task automatic rand_words();
    for (int n = 0; n < 4 * D; n++) wq[n] = $urandom;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    exp_k        = '0;
    @(posedge clk); #2;
    chk("rst_rdy", KW'(bus.in_ready), KW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_k", K, exp_k);
    chk("rst_rdy1", KW'(bus.in_ready), KW'(1));
    chk("rst_en", KW'(en), KW'(0));
    chk("rst_sel", KW'(sel), KW'(0));
    chk("rst_vld", KW'(rk_valid), KW'(0));
    chk("rst_done", KW'(done), KW'(0));
    chk("rst_round", KW'(rk_round), KW'(0));

    wq[0] = 32'h03020100; wq[1] = 32'h07060504; wq[2] = 32'h0B0A0908; wq[3] = 32'h0F0E0D0C;
    for (int n = 4; n < 4 * D; n++) wq[n] = 32'hFFFFFFFF;
    load_key(0, 0);
    chk("pack_lo", KW'(K[1:0]), KW'(2'b10));
    chk("pack_b1", KW'(K[17:16]), KW'(2'b11));
    chk("pack_hi", KW'(K[255:254]), KW'(2'b10));
    run_phase(-1, 0, -1, 1'b0);

    rand_words();
    load_key(0, 2);
    run_phase(10, 3, -1, 1'b0);

    rand_words();
    load_key(0, 3);
    run_phase(-1, 0, 20, 1'b0);
    rand_words();
    load_key(0, 1);
    run_phase(-1, 0, -1, 1'b1);

    rand_words();
    load_key(3, 1);
    load_key(0, 0);
    run_phase(-1, 0, -1, 1'b0);

    repeat (3) begin
      rand_words();
      load_key(0, 3);
      run_phase($urandom_range(0, ROUNDS - 1), $urandom_range(0, 4), -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/msk_tk3_sched_ctrl.md
Name: msk_tk3_sched_ctrl

Overview:
- Upstream feeder and sequencer for the masked TK3 key-schedule stage.
- Loads a d-share 128-bit tweakey word-by-word over a valid/ready bus.
- Packs the shares into the bit-interleaved masked layout and presents them on K.
- Drives the stage's sel/en so that it captures round 0 and then advances one round per non-stalled cycle, for ROUNDS rounds.
- Tells the datapath which round key is currently at the stage output.

Parameters:
d, 2, number of shares
ROUNDS, 56, round keys produced per tweakey (Skinny-128-384)
RW, 6, round-index width; must satisfy 2^RW >= ROUNDS

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  share word offered
in_ready  out  1  share word accepted when in_valid & in_ready
in_data  in  32  share word
hold  in  1  datapath stall; freezes round advance
K  out  128*d  masked tweakey to key-schedule stage
sel  out  1  stage mux select: 0 = load K, 1 = take rounded key
en  out  1  stage register enable
rk_valid  out  1  stage output holds round key rk_round
rk_round  out  RW  index of round key at stage output
done  out  1  one-cycle pulse after last round key consumed

Behaviour:
- Share packing: word n, for n = 0..4d-1, belongs to share s = n/4 and word w = n%4.
  - Bit b of in_data is bit j = 32w+b of share s.
  - It is stored at K[j*d+s]. Byte i of the tweakey therefore occupies K[(i+1)*8*d-1 : i*8*d].
- States: LOAD (reset state), INIT, RUN, DONE.
- LOAD:
  - in_ready=1. Each handshake writes one word and increments the word counter (0..4d-1).
  - The handshake on word 4d-1 goes to INIT and clears the counter.
  - Writes land at their interleaved bit positions only; all other K bits are unchanged.
- INIT (1 cycle):
  - in_ready=0, sel=0, en=1, so the stage captures K.
  - Next state is RUN with rk_round=0.
- RUN:
  - rk_valid=1, in_ready=0.
  - If hold=1: en=0, sel=1, no change.
  - If hold=0 and rk_round<ROUNDS-1: en=1, sel=1, rk_round++.
  - If hold=0 and rk_round==ROUNDS-1: en=0, go to DONE.
- DONE (1 cycle):
  - done=1, rk_valid=0, en=0.
  - K buffer zeroised (all 128*d bits cleared).
  - Next state is LOAD.
- Defaults:
  - Outside the cases above: sel=0, en=0, rk_valid=0, done=0.
  - rk_round holds its last value until the next INIT, which resets it to 0.
- Latency:
  - Last word accepted at cycle t: INIT at t+1, first rk_valid at t+2.
  - With hold low: RUN lasts ROUNDS cycles, done at t+2+ROUNDS.
  - Each hold-high cycle in RUN adds exactly one cycle.
- Reset (any state, including mid-load or mid-RUN), on the cycle after rst is sampled:
  - state=LOAD, word counter=0, K=0, rk_round=0.
  - sel=0, en=0, rk_valid=0, done=0.
  - in_ready is 0 while rst is high and 1 from the first cycle after rst deasserts.
- Masking hygiene:
  - Shares are never combined.
  - K is a register output with no logic between the buffer and the port.
  - Control outputs depend only on state, counters and hold, never on in_data.
- in_valid while in_ready=0 is ignored; data is dropped and no state changes.
- hold is ignored outside RUN.

Test Plan:
- Load and pack, d=2. Share0 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; share1 words all 0xFFFFFFFF.
  -> At INIT: K[1:0]=2'b10, K[17:16]=2'b11 (byte1 bit0), K[255:254]=2'b10. in_ready low after the 8th handshake. sel=0, en=1 for exactly one cycle.
- Free run, hold=0, ROUNDS=56.
  -> rk_valid high for 56 consecutive cycles, rk_round stepping 0..55. en high on the first 55 of them with sel=1. done pulses the cycle after rk_round=55. K reads 0 the cycle after done. in_ready=1.
- Stall. hold=1 for 3 cycles at rk_round=10.
  -> rk_round stays 10, en=0 for those 3 cycles. done is delayed by exactly 3 cycles versus the free run.
- Bus backpressure. in_valid asserted during RUN with data 0xDEADBEEF.
  -> No acceptance, K unchanged.
  -> In a following load, gaps (in_valid low) between words do not advance the word counter.
- Reset mid-RUN at rk_round=20.
  -> Next cycle: rk_valid=0, en=0, K=0, rk_round=0.
  -> A fresh 8-word load then produces rounds 0..55 normally.
- Reset mid-load after 3 words.
  -> The counter restarts. The next 8 words produce K identical to a clean load.
